// File: rtl/timer_mc_ctrl.sv
// Multi-channel timer core: per-channel prescaler, up-counter, compare and sticky match status
// on a flat word-addressed register bus, with per-channel and combined interrupt outputs.
module timer_mc_ctrl #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 32,
    parameter int DIV_MAX = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_addr,
    input  logic             i_wr_en,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic [NCH-1:0]   o_timer_en,
    output logic [NCH-1:0]   o_irq,
    output logic             o_irq_any
);

    logic [NCH-1:0]   r_timerEn;
    logic [NCH-1:0]   r_divEn;
    logic [NCH-1:0]   r_oneShot;
    logic [NCH-1:0]   r_intEn;
    logic [NCH-1:0]   r_sts;
    logic [3:0]       r_divVal [NCH];
    logic [14:0]      r_pre    [NCH];
    logic [CNT_W-1:0] r_cnt    [NCH];
    logic [CNT_W-1:0] r_cmp    [NCH];

    logic             w_aligned;
    logic             w_divOk;
    logic [NCH-1:0]   w_hit;
    logic [NCH-1:0]   w_wrTcr;
    logic [NCH-1:0]   w_wrCnt;
    logic [NCH-1:0]   w_wrCmp;
    logic [NCH-1:0]   w_wrSts;
    logic [NCH-1:0]   w_tick;
    logic [NCH-1:0]   w_match;

    // A CNT write in the same cycle as a tick suppresses both the increment and the match.
    always_comb begin
        w_aligned = (i_addr[1:0] == 2'b00);
        w_divOk   = (i_wdata[11:8] <= 4'(DIV_MAX));
        w_hit     = '0;
        w_wrTcr   = '0;
        w_wrCnt   = '0;
        w_wrCmp   = '0;
        w_wrSts   = '0;
        w_tick    = '0;
        w_match   = '0;
        for (int i = 0; i < NCH; i++) begin
            w_hit[i]   = w_aligned && (i_addr[31:4] == 28'(i));
            w_wrTcr[i] = i_wr_en && w_hit[i] && (i_addr[3:2] == 2'd0);
            w_wrCnt[i] = i_wr_en && w_hit[i] && (i_addr[3:2] == 2'd1);
            w_wrCmp[i] = i_wr_en && w_hit[i] && (i_addr[3:2] == 2'd2);
            w_wrSts[i] = i_wr_en && w_hit[i] && (i_addr[3:2] == 2'd3);
            w_tick[i]  = r_timerEn[i] &&
                         (!r_divEn[i] || (r_divVal[i] == 4'd0) ||
                          (r_pre[i] == ((15'd1 << r_divVal[i]) - 15'd1)));
            w_match[i] = w_tick[i] && !w_wrCnt[i] && (r_cnt[i] == r_cmp[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timerEn <= '0;
            r_divEn   <= '0;
            r_oneShot <= '0;
            r_intEn   <= '0;
            r_sts     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_divVal[i] <= 4'd1;
                r_pre[i]    <= '0;
                r_cnt[i]    <= '0;
                r_cmp[i]    <= '1;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_wrTcr[i]) begin
                    r_timerEn[i] <= i_wdata[0];
                    r_divEn[i]   <= i_wdata[1];
                    r_oneShot[i] <= i_wdata[16];
                    r_intEn[i]   <= i_wdata[17];
                    if (w_divOk) begin
                        r_divVal[i] <= i_wdata[11:8];
                    end
                end else if (w_match[i] && r_oneShot[i]) begin
                    r_timerEn[i] <= 1'b0;
                end

                if (!r_timerEn[i] || w_wrTcr[i] || w_tick[i]) begin
                    r_pre[i] <= '0;
                end else begin
                    r_pre[i] <= r_pre[i] + 15'd1;
                end

                if (w_wrCnt[i]) begin
                    r_cnt[i] <= i_wdata[CNT_W-1:0];
                end else if (w_match[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_tick[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end

                if (w_wrCmp[i]) begin
                    r_cmp[i] <= i_wdata[CNT_W-1:0];
                end

                // Hardware set takes priority over a simultaneous write-1-to-clear.
                if (w_match[i]) begin
                    r_sts[i] <= 1'b1;
                end else if (w_wrSts[i] && i_wdata[0]) begin
                    r_sts[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_hit[i]) begin
                case (i_addr[3:2])
                    2'd0: o_rdata = {14'b0, r_intEn[i], r_oneShot[i], 4'b0, r_divVal[i],
                                     6'b0, r_divEn[i], r_timerEn[i]};
                    2'd1: o_rdata[CNT_W-1:0] = r_cnt[i];
                    2'd2: o_rdata[CNT_W-1:0] = r_cmp[i];
                    default: o_rdata = {31'b0, r_sts[i]};
                endcase
            end
        end
    end

    assign o_timer_en = r_timerEn;
    assign o_irq      = r_sts & r_intEn;
    assign o_irq_any  = |o_irq;

endmodule

// File: tb/tb_timer_mc_ctrl.sv
// Scoreboard bench for timer_mc_ctrl: stimulus pushes hand-computed expectations tagged with
// the cycle they apply to; a negedge monitor pops and compares them against the DUT outputs.
module tb_timer_mc_ctrl;

    localparam int NCH   = 4;
    localparam int K_RD  = 0;
    localparam int K_TEN = 1;
    localparam int K_IRQ = 2;
    localparam int K_ANY = 3;

    logic           clk;
    logic           rst_n;
    logic [31:0]    i_addr;
    logic           i_wr_en;
    logic [31:0]    i_wdata;
    logic [31:0]    o_rdata;
    logic [NCH-1:0] o_timer_en;
    logic [NCH-1:0] o_irq;
    logic           o_irq_any;

    int             cycCount   = 0;
    int             numChecks  = 0;
    int             numFails   = 0;
    string          nameQ[$];
    int             kindQ[$];
    logic [31:0]    expQ[$];
    int             cycQ[$];

    timer_mc_ctrl #(.NCH(NCH), .CNT_W(32), .DIV_MAX(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_addr     (i_addr),
        .i_wr_en    (i_wr_en),
        .i_wdata    (i_wdata),
        .o_rdata    (o_rdata),
        .o_timer_en (o_timer_en),
        .o_irq      (o_irq),
        .o_irq_any  (o_irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycCount <= cycCount + 1;

    task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        i_wr_en = wr;
        i_addr  = a;
        i_wdata = d;
    endtask

    task automatic checkOutput(input string name, input int kind, input logic [31:0] exp);
        nameQ.push_back(name);
        kindQ.push_back(kind);
        expQ.push_back(exp);
        cycQ.push_back(cycCount);
    endtask

    // Monitor: compare every expectation tagged for the current cycle.
    always @(negedge clk) begin
        while (cycQ.size() > 0 && cycQ[0] <= cycCount) begin
            string       nm;
            int          kd;
            int          cy;
            logic [31:0] ex;
            logic [31:0] act;
            nm = nameQ.pop_front();
            kd = kindQ.pop_front();
            ex = expQ.pop_front();
            cy = cycQ.pop_front();
            case (kd)
                K_RD:    act = o_rdata;
                K_TEN:   act = 32'(o_timer_en);
                K_IRQ:   act = 32'(o_irq);
                default: act = {31'b0, o_irq_any};
            endcase
            numChecks++;
            if (cy != cycCount || act !== ex) begin
                numFails++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d, due %0d)",
                         nm, act, ex, cycCount, cy);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rstAddr [11];
        logic [31:0] rstExp  [11];
        logic [31:0] cntExp  [6];
        logic [31:0] osExp   [4];

        rstAddr = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h30, 32'h34, 32'h38, 32'h3C,
                    32'h40, 32'h01, 32'h06};
        rstExp  = '{32'h100, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h100, 32'h0, 32'hFFFF_FFFF,
                    32'h0, 32'h0, 32'h0, 32'h0};
        cntExp  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
        osExp   = '{32'd0, 32'd1, 32'd2, 32'd0};

        rst_n   = 1'b0;
        i_wr_en = 1'b0;
        i_addr  = '0;
        i_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] reset values");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, rstAddr[i], 32'h0);
            checkOutput("reset read", K_RD, rstExp[i]);
        end
        checkOutput("reset timer_en", K_TEN, 32'h0);
        checkOutput("reset irq", K_IRQ, 32'h0);
        checkOutput("reset irq_any", K_ANY, 32'h0);
        applyStimulus(1'b1, 32'h09, 32'd5);
        applyStimulus(1'b1, 32'h48, 32'd5);
        applyStimulus(1'b0, 32'h08, 32'h0);
        checkOutput("ignored writes ch0 CMP", K_RD, 32'hFFFF_FFFF);

        $display("[TB] ch0 free-running with interrupt");
        applyStimulus(1'b1, 32'h08, 32'd4);
        applyStimulus(1'b1, 32'h00, 32'h0002_0001);
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b0, 32'h04, 32'h0);
            checkOutput("ch0 CNT sequence", K_RD, cntExp[j]);
            if (j == 0) checkOutput("ch0 timer_en", K_TEN, 32'h1);
            if (j == 4) checkOutput("ch0 irq before match", K_IRQ, 32'h0);
            if (j == 5) begin
                checkOutput("ch0 irq after match", K_IRQ, 32'h1);
                checkOutput("ch0 irq_any after match", K_ANY, 32'h1);
            end
        end
        applyStimulus(1'b0, 32'h0C, 32'h0);
        checkOutput("ch0 STS set", K_RD, 32'h1);
        applyStimulus(1'b1, 32'h0C, 32'h1);
        applyStimulus(1'b1, 32'h00, 32'h0);
        checkOutput("ch0 irq after W1C", K_IRQ, 32'h0);
        checkOutput("ch0 irq_any after W1C", K_ANY, 32'h0);
        applyStimulus(1'b0, 32'h0C, 32'h0);
        checkOutput("ch0 STS cleared", K_RD, 32'h0);
        checkOutput("ch0 stopped", K_TEN, 32'h0);

        $display("[TB] ch1 prescaler div_val 3");
        applyStimulus(1'b1, 32'h10, 32'h0000_0303);
        for (int j = 1; j <= 17; j++) begin
            applyStimulus(1'b0, 32'h14, 32'h0);
            checkOutput("ch1 prescaled CNT", K_RD, (j >= 17) ? 32'd2 : (j >= 9) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 32'h10, 32'h0000_0903);
        applyStimulus(1'b0, 32'h10, 32'h0);
        checkOutput("ch1 TCR illegal div_val", K_RD, 32'h0000_0303);
        applyStimulus(1'b1, 32'h10, 32'h0000_0800);
        applyStimulus(1'b0, 32'h10, 32'h0);
        checkOutput("ch1 TCR div_val at max", K_RD, 32'h0000_0800);
        checkOutput("ch1 stopped", K_TEN, 32'h0);

        $display("[TB] ch2 one-shot");
        applyStimulus(1'b1, 32'h28, 32'd2);
        applyStimulus(1'b1, 32'h20, 32'h0001_0001);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 32'h24, 32'h0);
            checkOutput("ch2 one-shot CNT", K_RD, osExp[j]);
            if (j == 1) checkOutput("ch2 running", K_TEN, 32'h4);
            if (j == 3) checkOutput("ch2 one-shot stop", K_TEN, 32'h0);
        end
        applyStimulus(1'b0, 32'h2C, 32'h0);
        checkOutput("ch2 STS", K_RD, 32'h1);
        applyStimulus(1'b0, 32'h24, 32'h0);
        checkOutput("ch2 CNT held", K_RD, 32'h0);
        applyStimulus(1'b0, 32'h20, 32'h0);
        checkOutput("ch2 TCR after one-shot", K_RD, 32'h0001_0000);

        $display("[TB] ch0 write collisions");
        applyStimulus(1'b1, 32'h08, 32'd20);
        applyStimulus(1'b1, 32'h00, 32'h1);
        applyStimulus(1'b1, 32'h04, 32'd10);
        applyStimulus(1'b0, 32'h04, 32'h0);
        checkOutput("CNT write beats tick", K_RD, 32'd10);
        applyStimulus(1'b1, 32'h08, 32'd13);
        applyStimulus(1'b0, 32'h04, 32'h0);
        checkOutput("ch0 CNT before match", K_RD, 32'd12);
        applyStimulus(1'b1, 32'h0C, 32'h1);
        applyStimulus(1'b0, 32'h0C, 32'h0);
        checkOutput("match set beats W1C", K_RD, 32'h1);
        checkOutput("irq masked without int_en", K_IRQ, 32'h0);
        applyStimulus(1'b0, 32'h04, 32'h0);
        checkOutput("ch0 CNT after wrap", K_RD, 32'd1);

        $display("[TB] independence and async reset");
        applyStimulus(1'b1, 32'h38, 32'd1000);
        applyStimulus(1'b1, 32'h30, 32'h0002_0001);
        applyStimulus(1'b1, 32'h00, 32'h0002_0001);
        applyStimulus(1'b1, 32'h04, 32'd0);
        applyStimulus(1'b0, 32'h34, 32'h0);
        checkOutput("ch3 CNT", K_RD, 32'd2);
        checkOutput("ch0 irq pending", K_IRQ, 32'h1);
        checkOutput("irq_any pending", K_ANY, 32'h1);
        applyStimulus(1'b0, 32'h04, 32'h0);
        checkOutput("ch0 CNT after write", K_RD, 32'd1);
        applyStimulus(1'b0, 32'h34, 32'h0);
        checkOutput("ch3 CNT unaffected", K_RD, 32'd4);

        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        i_wr_en = 1'b0;
        i_addr  = 32'h34;
        checkOutput("async reset ch3 CNT", K_RD, 32'h0);
        checkOutput("async reset timer_en", K_TEN, 32'h0);
        checkOutput("async reset irq", K_IRQ, 32'h0);
        checkOutput("async reset irq_any", K_ANY, 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        i_addr = 32'h30;
        checkOutput("post-reset ch3 TCR", K_RD, 32'h100);
        applyStimulus(1'b0, 32'h38, 32'h0);
        checkOutput("post-reset ch3 CMP", K_RD, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h0C, 32'h0);
        checkOutput("post-reset ch0 STS", K_RD, 32'h0);
        applyStimulus(1'b0, 32'h04, 32'h0);
        checkOutput("post-reset ch0 CNT", K_RD, 32'h0);
        applyStimulus(1'b0, 32'h00, 32'h0);
        checkOutput("post-reset ch0 TCR", K_RD, 32'h100);

        repeat (2) applyStimulus(1'b0, 32'h0, 32'h0);
        if (cycQ.size() != 0) begin
            numFails += cycQ.size();
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", cycQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
